// File: rtl/mrv1_wb_retire_pkg.sv
// Shared widths and the writeback packet carried by the holding slots and output stage.
package mrv1_wb_retire_pkg;

   localparam int unsigned NUM_FU_P        = 3;
   localparam int unsigned NUM_TW_P        = 8;
   localparam int unsigned DATA_WIDTH_P    = 32;
   localparam int unsigned ITAG_WIDTH_P    = 3;
   localparam int unsigned rf_addr_width_p = 5;
   localparam int unsigned TWID_WIDTH_LP   = $clog2(NUM_TW_P);

   typedef struct packed {
      logic [TWID_WIDTH_LP-1:0]   twid;
      logic [ITAG_WIDTH_P-1:0]    itag;
      logic                       rd_vld;
      logic [rf_addr_width_p-1:0] rd_addr;
      logic [DATA_WIDTH_P-1:0]    data;
   } xrv_wb_pkt_t;

   // A packet updates architectural state only if it has a destination other than x0.
   function automatic logic writes_rf(input xrv_wb_pkt_t p);
      return p.rd_vld & (p.rd_addr != '0);
   endfunction

endpackage

// File: rtl/mrv1_wb_retire_if.sv
// FU result ports plus retire / RF write / bypass outputs of the writeback stage.
interface mrv1_wb_retire_if;
   import mrv1_wb_retire_pkg::*;

   logic [NUM_FU_P-1:0]                 fu_vld_i;
   logic [NUM_FU_P-1:0]                 fu_rdy_o;
   logic [NUM_FU_P*TWID_WIDTH_LP-1:0]   fu_twid_i;
   logic [NUM_FU_P*ITAG_WIDTH_P-1:0]    fu_itag_i;
   logic [NUM_FU_P-1:0]                 fu_rd_vld_i;
   logic [NUM_FU_P*rf_addr_width_p-1:0] fu_rd_addr_i;
   logic [NUM_FU_P*DATA_WIDTH_P-1:0]    fu_data_i;

   logic                                retire_rdy_i;
   logic                                retire_vld_o;
   logic [TWID_WIDTH_LP-1:0]            retire_twid_o;
   logic [ITAG_WIDTH_P-1:0]             retire_itag_o;

   logic                                rf_we_o;
   logic [TWID_WIDTH_LP-1:0]            rf_twid_o;
   logic [rf_addr_width_p-1:0]          rf_waddr_o;
   logic [DATA_WIDTH_P-1:0]             rf_wdata_o;

   logic                                byp_vld_o;
   logic [TWID_WIDTH_LP-1:0]            byp_twid_o;
   logic [rf_addr_width_p-1:0]          byp_addr_o;
   logic [DATA_WIDTH_P-1:0]             byp_data_o;

   // FU / iqueue side
   modport master (
      output fu_vld_i, fu_twid_i, fu_itag_i, fu_rd_vld_i, fu_rd_addr_i, fu_data_i, retire_rdy_i,
      input  fu_rdy_o, retire_vld_o, retire_twid_o, retire_itag_o,
             rf_we_o, rf_twid_o, rf_waddr_o, rf_wdata_o,
             byp_vld_o, byp_twid_o, byp_addr_o, byp_data_o
   );

   // writeback stage side
   modport slave (
      input  fu_vld_i, fu_twid_i, fu_itag_i, fu_rd_vld_i, fu_rd_addr_i, fu_data_i, retire_rdy_i,
      output fu_rdy_o, retire_vld_o, retire_twid_o, retire_itag_o,
             rf_we_o, rf_twid_o, rf_waddr_o, rf_wdata_o,
             byp_vld_o, byp_twid_o, byp_addr_o, byp_data_o
   );

endinterface

// File: rtl/mrv1_wb_rr_arb.sv
// Round-robin request/grant arbiter; the pointer moves past the winner only on a grant.
module mrv1_wb_rr_arb #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         gnt_vld
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] gnt_idx;

   // Position 'ofs' steps after 'base' on the ring of N requesters.
   function automatic logic [PTR_W-1:0] ring_pos(input logic [PTR_W-1:0] base, input int unsigned ofs);
      int unsigned s;
      s = 32'(base) + ofs;
      if (s >= N) s = s - N;
      return PTR_W'(s);
   endfunction

   // First requester at or after the pointer wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!gnt_vld && req[ring_pos(ptr, i)]) begin
            gnt[ring_pos(ptr, i)] = 1'b1;
            gnt_vld               = 1'b1;
            gnt_idx               = ring_pos(ptr, i);
         end
      end
   end

   // Pointer advances to the slot after the winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (gnt_vld) begin
         ptr <= ring_pos(gnt_idx, 1);
      end
   end

endmodule

// File: rtl/mrv1_wb_retire.sv
// Writeback/retire stage: per-FU holding slots, in-order-per-thread retire, registered output stage.
module mrv1_wb_retire
   import mrv1_wb_retire_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   mrv1_wb_retire_if.slave wb
);

   xrv_wb_pkt_t               in_pkt   [NUM_FU_P];
   xrv_wb_pkt_t               slot_pkt [NUM_FU_P];
   logic [NUM_FU_P-1:0]       slot_vld;
   logic [NUM_FU_P-1:0]       slot_req;
   logic [NUM_FU_P-1:0]       slot_gnt;
   logic [NUM_FU_P-1:0]       slot_load;
   logic [NUM_FU_P-1:0]       fu_rdy;
   logic                      gnt_vld;
   xrv_wb_pkt_t               sel_pkt;

   logic [ITAG_WIDTH_P-1:0]   next_itag [NUM_TW_P];

   logic                      out_vld;
   xrv_wb_pkt_t               out_pkt;
   logic                      adv;
   logic                      commit;
   logic                      slot_dup;

   assign adv    = ~out_vld | wb.retire_rdy_i;
   assign commit = out_vld & wb.retire_rdy_i;

   // Slice the flat FU buses into packets; eligibility uses the registered next_itag only.
   for (genvar g = 0; g < NUM_FU_P; g++) begin : g_fu
      assign in_pkt[g] = {wb.fu_twid_i[g*TWID_WIDTH_LP +: TWID_WIDTH_LP],
                          wb.fu_itag_i[g*ITAG_WIDTH_P +: ITAG_WIDTH_P],
                          wb.fu_rd_vld_i[g],
                          wb.fu_rd_addr_i[g*rf_addr_width_p +: rf_addr_width_p],
                          wb.fu_data_i[g*DATA_WIDTH_P +: DATA_WIDTH_P]};
      assign slot_req[g] = adv & slot_vld[g] & (slot_pkt[g].itag == next_itag[slot_pkt[g].twid]);
   end

   // A slot is free when empty or being drained this cycle.
   assign fu_rdy      = ~slot_vld | slot_gnt;
   assign slot_load   = wb.fu_vld_i & fu_rdy;
   assign wb.fu_rdy_o = fu_rdy;

   mrv1_wb_rr_arb #(
      .N (NUM_FU_P)
   ) u_arb (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .req     (slot_req),
      .gnt     (slot_gnt),
      .gnt_vld (gnt_vld)
   );

   // One-hot select of the granted slot.
   always_comb begin
      sel_pkt = '0;
      for (int f = 0; f < NUM_FU_P; f++) begin
         if (slot_gnt[f]) sel_pkt = slot_pkt[f];
      end
   end

   // Holding slots: refill wins over drain so same-cycle drain/refill keeps the slot full.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         slot_vld <= '0;
         for (int f = 0; f < NUM_FU_P; f++) slot_pkt[f] <= '0;
      end else begin
         for (int f = 0; f < NUM_FU_P; f++) begin
            if (slot_load[f]) begin
               slot_vld[f] <= 1'b1;
               slot_pkt[f] <= in_pkt[f];
            end else if (slot_gnt[f]) begin
               slot_vld[f] <= 1'b0;
            end
         end
      end
   end

   // Output stage: take the grant, else empty once the held insn commits.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_vld <= 1'b0;
         out_pkt <= '0;
      end else if (gnt_vld) begin
         out_vld <= 1'b1;
         out_pkt <= sel_pkt;
      end else if (wb.retire_rdy_i) begin
         out_vld <= 1'b0;
      end
   end

   // Per-thread next expected itag; single write port on commit, wraps naturally.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int t = 0; t < NUM_TW_P; t++) next_itag[t] <= '0;
      end else if (commit) begin
         next_itag[out_pkt.twid] <= next_itag[out_pkt.twid] + ITAG_WIDTH_P'(1);
      end
   end

   assign wb.retire_vld_o  = out_vld;
   assign wb.retire_twid_o = out_pkt.twid;
   assign wb.retire_itag_o = out_pkt.itag;

   assign wb.rf_we_o       = commit & writes_rf(out_pkt);
   assign wb.rf_twid_o     = out_pkt.twid;
   assign wb.rf_waddr_o    = out_pkt.rd_addr;
   assign wb.rf_wdata_o    = out_pkt.data;

   assign wb.byp_vld_o     = out_vld & writes_rf(out_pkt);
   assign wb.byp_twid_o    = out_pkt.twid;
   assign wb.byp_addr_o    = out_pkt.rd_addr;
   assign wb.byp_data_o    = out_pkt.data;

   // Two valid slots naming the same {twid,itag} is an upstream protocol error.
   always_comb begin
      slot_dup = 1'b0;
      for (int a = 0; a < NUM_FU_P; a++) begin
         for (int b = a + 1; b < NUM_FU_P; b++) begin
            if (slot_vld[a] && slot_vld[b] &&
                slot_pkt[a].twid == slot_pkt[b].twid &&
                slot_pkt[a].itag == slot_pkt[b].itag) begin
               slot_dup = 1'b1;
            end
         end
      end
   end

   // Upstream must never present duplicate tags.
   a_no_dup : assert property (@(posedge clk_i) disable iff (!rst_i) !slot_dup)
      else $error("mrv1_wb_retire: duplicate twid/itag in holding slots");

endmodule

// File: tb/tb_mrv1_wb_retire.sv
// Bench for mrv1_wb_retire: directed scenarios plus random traffic against a per-thread in-order model.
module tb_mrv1_wb_retire;
   import mrv1_wb_retire_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mrv1_wb_retire_if wb();

   mrv1_wb_retire dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .wb    (wb)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random

   xrv_wb_pkt_t fu_q  [NUM_FU_P][$];   // pending results per FU, head is presented
   xrv_wb_pkt_t thr_q [NUM_TW_P][$];   // program order per thread = required retire order
   xrv_wb_pkt_t ret_log[$];
   int          ret_cyc[$];
   int          iss_itag [NUM_TW_P];

   logic                     prev_stall;
   logic [TWID_WIDTH_LP-1:0] prev_tw;
   logic [ITAG_WIDTH_P-1:0]  prev_it;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic xrv_wb_pkt_t mk(input int tw, input int itag, input int rdv, input int addr,
                                      input logic [31:0] data);
      xrv_wb_pkt_t p;
      p.twid    = TWID_WIDTH_LP'(tw);
      p.itag    = ITAG_WIDTH_P'(itag);
      p.rd_vld  = 1'(rdv);
      p.rd_addr = rf_addr_width_p'(addr);
      p.data    = DATA_WIDTH_P'(data);
      return p;
   endfunction

   function automatic int pending();
      int n = 0;
      for (int t = 0; t < NUM_TW_P; t++) n += thr_q[t].size();
      return n;
   endfunction

   task automatic issue(input int f, input xrv_wb_pkt_t p);
      fu_q[f].push_back(p);
      thr_q[p.twid].push_back(p);
   endtask

   task automatic drive();
      for (int f = 0; f < NUM_FU_P; f++) begin
         if (fu_q[f].size() > 0) begin
            wb.fu_vld_i[f]                                        = 1'b1;
            wb.fu_twid_i[f*TWID_WIDTH_LP +: TWID_WIDTH_LP]         = fu_q[f][0].twid;
            wb.fu_itag_i[f*ITAG_WIDTH_P +: ITAG_WIDTH_P]           = fu_q[f][0].itag;
            wb.fu_rd_vld_i[f]                                     = fu_q[f][0].rd_vld;
            wb.fu_rd_addr_i[f*rf_addr_width_p +: rf_addr_width_p]  = fu_q[f][0].rd_addr;
            wb.fu_data_i[f*DATA_WIDTH_P +: DATA_WIDTH_P]           = fu_q[f][0].data;
         end else begin
            wb.fu_vld_i[f] = 1'b0;
         end
      end
      wb.retire_rdy_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
   endtask

   // Consume accepted results and compare the retire/RF/bypass outputs against the model.
   task automatic observe();
      int          tw;
      logic        wr;
      xrv_wb_pkt_t e;
      for (int f = 0; f < NUM_FU_P; f++)
         if (wb.fu_vld_i[f] && wb.fu_rdy_o[f]) void'(fu_q[f].pop_front());
      if (prev_stall) begin
         chk("hold_vld", 64'(wb.retire_vld_o), 64'(1));
         chk("hold_tag", 64'({wb.retire_twid_o, wb.retire_itag_o}), 64'({prev_tw, prev_it}));
      end
      if (wb.retire_vld_o) begin
         tw = int'(wb.retire_twid_o);
         if (thr_q[tw].size() == 0) begin
            chk("ret_unexpected_thread", 64'(thr_q[tw].size()), 64'(1));
         end else begin
            e  = thr_q[tw][0];
            wr = e.rd_vld && (e.rd_addr != 0);
            chk("ret_itag", 64'(wb.retire_itag_o), 64'(e.itag));
            chk("byp_vld", 64'(wb.byp_vld_o), 64'(wr));
            if (wr)
               chk("byp_fields", 64'({wb.byp_twid_o, wb.byp_addr_o, wb.byp_data_o}),
                   64'({e.twid, e.rd_addr, e.data}));
            chk("rf_we", 64'(wb.rf_we_o), 64'(wr && wb.retire_rdy_i));
            if (wr && wb.retire_rdy_i)
               chk("rf_fields", 64'({wb.rf_twid_o, wb.rf_waddr_o, wb.rf_wdata_o}),
                   64'({e.twid, e.rd_addr, e.data}));
            if (wb.retire_rdy_i) begin
               void'(thr_q[tw].pop_front());
               ret_log.push_back(e);
               ret_cyc.push_back(cyc);
            end
         end
      end else begin
         chk("idle_we_byp", 64'({wb.rf_we_o, wb.byp_vld_o}), 64'(0));
      end
      prev_stall = wb.retire_vld_o && !wb.retire_rdy_i;
      prev_tw    = wb.retire_twid_o;
      prev_it    = wb.retire_itag_o;
   endtask

   task automatic cyc_begin();
      drive();
      #1;
      observe();
   endtask

   task automatic cyc_end();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         cyc_begin();
         cyc_end();
      end
   endtask

   task automatic drain(input string tag, input int bound);
      int n = 0;
      rdy_mode = 0;
      while (pending() > 0 && n < bound) begin
         run(1);
         n++;
      end
      chk(tag, 64'(pending()), 64'(0));
      run(2);
   endtask

   // Leaves the cycle open once retire_vld_o is seen so the caller can inspect it.
   task automatic open_until_ret(input string tag);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cyc_begin();
         if (wb.retire_vld_o) seen = 1;
         else cyc_end();
      end
      chk(tag, 64'(seen), 64'(1));
      if (!seen) cyc_begin();
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      wb.fu_vld_i     = '0;
      wb.retire_rdy_i = 1'b0;
      for (int f = 0; f < NUM_FU_P; f++) fu_q[f].delete();
      for (int t = 0; t < NUM_TW_P; t++) begin
         thr_q[t].delete();
         iss_itag[t] = 0;
      end
      ret_log.delete();
      ret_cyc.delete();
      prev_stall = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_vld"},  64'(wb.retire_vld_o), 64'(0));
      chk({tag, "_rdy"},  64'(wb.fu_rdy_o), 64'(3'b111));
      chk({tag, "_we"},   64'({wb.rf_we_o, wb.byp_vld_o}), 64'(0));
      chk({tag, "_tags"}, 64'({wb.retire_twid_o, wb.retire_itag_o, wb.rf_waddr_o}), 64'(0));
      chk({tag, "_data"}, 64'({wb.rf_wdata_o, wb.byp_data_o}), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      xrv_wb_pkt_t p0, p1;
      int          issued;
      wb.fu_vld_i     = '0;
      wb.fu_twid_i    = '0;
      wb.fu_itag_i    = '0;
      wb.fu_rd_vld_i  = '0;
      wb.fu_rd_addr_i = '0;
      wb.fu_data_i    = '0;
      wb.retire_rdy_i = 1'b0;
      prev_stall      = 1'b0;
      prev_tw         = '0;
      prev_it         = '0;

      // Power-on reset values
      #2;
      chk_reset_outputs("por");
      do_reset();

      // In-order within a thread: itag1 arrives a cycle before itag0
      p0 = mk(2, 0, 1, 3, 32'h0000_1000);
      p1 = mk(2, 1, 1, 4, 32'h0000_1001);
      thr_q[2].push_back(p0);
      thr_q[2].push_back(p1);
      fu_q[1].push_back(p1);
      run(1);
      fu_q[0].push_back(p0);
      drain("inorder_drain", 30);
      chk("inorder_cnt", 64'(ret_log.size()), 64'(2));
      chk("inorder_first", 64'(ret_log[0].itag), 64'(0));
      chk("inorder_second", 64'(ret_log[1].itag), 64'(1));

      // Round-robin fairness: three threads always eligible, one retire per cycle
      do_reset();
      for (int k = 0; k < 3; k++)
         for (int f = 0; f < NUM_FU_P; f++)
            issue(f, mk(f, k, 1, f + 1, $urandom));
      drain("rr_drain", 40);
      chk("rr_cnt", 64'(ret_log.size()), 64'(9));
      for (int i = 0; i < 9; i++) begin
         chk("rr_order", 64'(ret_log[i].twid), 64'(i % 3));
         chk("rr_rate", 64'(ret_cyc[i] - ret_cyc[0]), 64'(i));
      end

      // Itag wrap on thread 0: 0..7,0,1 then 2
      do_reset();
      for (int k = 0; k < 10; k++) issue(k % 3, mk(0, k % 8, 1, 7, $urandom));
      drain("wrap_drain", 60);
      chk("wrap_cnt", 64'(ret_log.size()), 64'(10));
      for (int k = 0; k < 10; k++) chk("wrap_order", 64'(ret_log[k].itag), 64'(k % 8));
      issue(1, mk(0, 2, 1, 7, 32'h0000_0222));
      drain("wrap_next_drain", 20);
      chk("wrap_next", 64'(ret_log.size()), 64'(11));

      // x0 writes suppressed; bypass visible while held, RF write only on retire_rdy
      do_reset();
      rdy_mode = 1;
      issue(0, mk(1, 0, 1, 0, 32'h0000_1234));
      open_until_ret("x0_wait");
      chk("x0_byp", 64'(wb.byp_vld_o), 64'(0));
      chk("x0_we_stall", 64'(wb.rf_we_o), 64'(0));
      cyc_end();
      rdy_mode = 0;
      cyc_begin();
      chk("x0_we_rdy", 64'({wb.retire_vld_o, wb.rf_we_o}), 64'(2'b10));
      cyc_end();
      rdy_mode = 1;
      issue(0, mk(1, 1, 1, 5, 32'hDEAD_BEEF));
      open_until_ret("byp_wait");
      chk("byp_vld_held", 64'(wb.byp_vld_o), 64'(1));
      chk("byp_data_held", 64'({wb.byp_twid_o, wb.byp_addr_o, wb.byp_data_o}), 64'({3'd1, 5'd5, 32'hDEAD_BEEF}));
      chk("byp_we_stall", 64'(wb.rf_we_o), 64'(0));
      cyc_end();
      cyc_begin();
      chk("byp_data_hold2", 64'(wb.byp_data_o), 64'(32'hDEAD_BEEF));
      cyc_end();
      rdy_mode = 0;
      cyc_begin();
      chk("rf_we_commit", 64'(wb.rf_we_o), 64'(1));
      chk("rf_fields_commit", 64'({wb.rf_twid_o, wb.rf_waddr_o, wb.rf_wdata_o}), 64'({3'd1, 5'd5, 32'hDEAD_BEEF}));
      cyc_end();
      cyc_begin();
      chk("byp_after_commit", 64'({wb.retire_vld_o, wb.byp_vld_o}), 64'(0));
      cyc_end();

      // Backpressure: frozen output, full slots not ready, same-cycle refill on release
      do_reset();
      rdy_mode = 1;
      for (int t = 0; t < 5; t++) issue(t % 3, mk(t, 0, 1, t + 8, $urandom));
      run(3);
      for (int i = 0; i < 5; i++) begin
         cyc_begin();
         chk("bp_rdy_full", 64'(wb.fu_rdy_o), 64'(3'b000));
         chk("bp_out_frozen", 64'({wb.retire_vld_o, wb.retire_twid_o, wb.retire_itag_o}), 64'({1'b1, 3'd0, 3'd0}));
         chk("bp_no_we", 64'(wb.rf_we_o), 64'(0));
         cyc_end();
      end
      rdy_mode = 0;
      cyc_begin();
      chk("bp_refill_rdy", 64'(wb.fu_rdy_o), 64'(3'b010));
      cyc_end();
      drain("bp_drain", 30);
      chk("bp_cnt", 64'(ret_log.size()), 64'(5));
      for (int i = 0; i < 5; i++) chk("bp_order", 64'(ret_log[i].twid), 64'(i));

      // Reset while stalled with all slots full
      do_reset();
      rdy_mode = 1;
      for (int t = 0; t < 4; t++) issue(t % 3, mk(t + 4, 0, 1, 9, $urandom));
      run(3);
      chk("rst_pre_full", 64'(wb.fu_rdy_o), 64'(3'b000));
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      do_reset();
      for (int t = 0; t < NUM_TW_P; t++) issue(t % 3, mk(t, 0, 1, t + 1, $urandom));
      drain("rst_itag0_drain", 40);
      chk("rst_itag0_cnt", 64'(ret_log.size()), 64'(8));

      // Random traffic with random retire backpressure
      do_reset();
      rdy_mode = 2;
      issued   = 0;
      for (int c = 0; c < 600; c++) begin
         for (int f = 0; f < NUM_FU_P; f++) begin
            if (fu_q[f].size() == 0 && $urandom_range(0, 3) != 0) begin
               int tw;
               tw = int'($urandom_range(0, NUM_TW_P - 1));
               if (thr_q[tw].size() < 4) begin
                  issue(f, mk(tw, iss_itag[tw], int'($urandom_range(0, 1)),
                              int'($urandom_range(0, 31)), $urandom));
                  iss_itag[tw] = (iss_itag[tw] + 1) % 8;
                  issued++;
               end
            end
         end
         run(1);
      end
      drain("rand_drain", 300);
      chk("rand_cnt", 64'(ret_log.size()), 64'(issued));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
